// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_if.sv
// Write port of the UART transmitter: valid/ready handshake carrying one word.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered count; pop_data shows the head entry, valid in the pop cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: buffered words are framed (start, LSB-first data, optional parity, 1/2 stop)
// and sent back-to-back on txd at a runtime baud divisor.
//
// state  | meaning
// OFF    | transmitter disabled, txd idle high
// IDLE   | enabled, waiting for a buffered word
// START  | start bit (0)
// DATA   | payload bits, LSB first
// PARITY | even/odd parity bit
// STOP   | one or two stop bits (1)
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_en,
  input  logic [DIV_WIDTH-1:0]         baud_div,
  input  logic [1:0]                   parity_mode,
  input  logic                         stop2,
  uart_tx_if.slave                     wr,
  output logic                         txd,
  output logic                         tx_busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_TOP = BW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_l;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l;
  logic                 par_bit_l;
  logic                 stop2_l;
  logic                 stop_idx;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 last_tick;
  logic                 stop_last;
  logic                 frame_end;
  logic                 start_next;
  logic                 done_nxt;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (start_next),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr.wr_ready = !fifo_full;
  assign last_tick   = (baud_cnt == div_l);
  assign stop_last   = (stop_idx == stop2_l);
  assign frame_end   = (state == ST_STOP) && last_tick && stop_last;
  assign start_next  = tx_en && !fifo_empty && ((state == ST_IDLE) || frame_end);

  // tx_done is registered, so predict whether the next cycle is the final cycle of the last stop bit.
  assign done_nxt = last_tick
    ? ((div_l == '0) &&
       (((state == ST_STOP) && !stop_last) ||
        (!stop2_l && ((state == ST_PARITY) ||
                      ((state == ST_DATA) && (bit_cnt == '0) && !par_en_l)))))
    : ((state == ST_STOP) && stop_last && ((baud_cnt + DIV_WIDTH'(1)) == div_l));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      baud_cnt  <= '0;
      div_l     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      stop2_l   <= 1'b0;
      stop_idx  <= 1'b0;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= done_nxt;
      if (start_next) begin
        state     <= ST_START;
        baud_cnt  <= '0;
        div_l     <= baud_div;
        shreg     <= fifo_rdata;
        par_en_l  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit_l <= (^fifo_rdata) ^ (parity_mode == PAR_ODD);
        stop2_l   <= stop2;
        txd       <= 1'b0;
        tx_busy   <= 1'b1;
      end else begin
        case (state)
          ST_OFF:  if (tx_en) state <= ST_IDLE;
          ST_IDLE: if (!tx_en) state <= ST_OFF;
          default: begin
            if (!last_tick) begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end else begin
              baud_cnt <= '0;
              case (state)
                ST_START: begin
                  state   <= ST_DATA;
                  bit_cnt <= BIT_TOP;
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
                end
                ST_DATA: begin
                  if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - BW'(1);
                    txd     <= shreg[0];
                    shreg   <= shreg >> 1;
                  end else if (par_en_l) begin
                    state <= ST_PARITY;
                    txd   <= par_bit_l;
                  end else begin
                    state    <= ST_STOP;
                    stop_idx <= 1'b0;
                    txd      <= 1'b1;
                  end
                end
                ST_PARITY: begin
                  state    <= ST_STOP;
                  stop_idx <= 1'b0;
                  txd      <= 1'b1;
                end
                ST_STOP: begin
                  if (!stop_last) begin
                    stop_idx <= 1'b1;
                  end else begin
                    state   <= ST_IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                  end
                end
                default: state <= ST_OFF;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: reset, parity variants, FIFO full/drain, disable and reset mid-frame.
module tb_uart_tx_core;
  import uart_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        txd;
  logic        tx_busy;
  logic        tx_done;
  logic [2:0]  fifo_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  uart_tx_if #(.DATA_BITS(8)) wr_if ();

  uart_tx_core #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4),
    .DIV_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_en       (tx_en),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .wr          (wr_if.slave),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks frame cycles [first, upto) of a frame whose line levels are bits[0..nbits-1], each held div+1 cycles.
  task automatic frame_check(input string tag, input logic [15:0] bits, input int nbits,
                             input int div, input int first, input int upto);
    int total;
    total = nbits * (div + 1);
    for (int c = first; c < upto; c++) begin
      @(negedge clk);
      chk({tag, "_txd"},  {31'd0, txd},     {31'd0, bits[c / (div + 1)]});
      chk({tag, "_busy"}, {31'd0, tx_busy}, 32'd1);
      chk({tag, "_done"}, {31'd0, tx_done}, (c == total - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic idle_check(input string tag, input int exp_count);
    chk({tag, "_txd"},   {31'd0, txd},        32'd1);
    chk({tag, "_busy"},  {31'd0, tx_busy},    32'd0);
    chk({tag, "_done"},  {31'd0, tx_done},    32'd0);
    chk({tag, "_count"}, {29'd0, fifo_count}, exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    tx_en          = 1'b0;
    baud_div       = 16'd3;
    parity_mode    = PAR_EVEN;
    stop2          = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    idle_check("rst", 0);
    chk("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    reset = 1'b0;

    // pending write while disabled: nothing moves
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'hA5;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      idle_check("off_hold", 1);
    end

    // even parity, baud_div=3, one stop: 44-cycle frame
    tx_en = 1'b1;
    @(negedge clk);
    chk("even_pre_txd", {31'd0, txd}, 32'd1);
    frame_check("even", {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 3, 0, 44);
    @(negedge clk);
    idle_check("even_post", 0);

    // odd parity, two stops, baud_div=0; also push-to-start latency from IDLE
    parity_mode    = PAR_ODD;
    stop2          = 1'b1;
    baud_div       = 16'd0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h00;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    chk("lat_txd",   {31'd0, txd},        32'd1);
    chk("lat_busy",  {31'd0, tx_busy},    32'd0);
    chk("lat_count", {29'd0, fifo_count}, 32'd1);
    frame_check("odd2", {4'd0, 2'b11, 1'b1, 8'h00, 1'b0}, 12, 0, 0, 12);
    @(negedge clk);
    idle_check("odd2_post", 0);

    // FIFO full with transmitter disabled
    tx_en       = 1'b0;
    parity_mode = PAR_NONE;
    stop2       = 1'b0;
    baud_div    = 16'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = words[i];
      chk("full_ready", {31'd0, wr_if.wr_ready}, (i < 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    chk("full_count", {29'd0, fifo_count},     32'd4);
    chk("full_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    chk("full_txd",   {31'd0, txd},            32'd1);

    // drain: four frames back-to-back, busy held high throughout
    tx_en = 1'b1;
    @(negedge clk);
    chk("drain_pre_txd", {31'd0, txd}, 32'd1);
    for (int i = 0; i < 4; i++)
      frame_check("drain", {6'd0, 1'b1, words[i], 1'b0}, 10, 1, 0, 20);
    @(negedge clk);
    idle_check("drain_post", 0);
    chk("drain_ready", {31'd0, wr_if.wr_ready}, 32'd1);

    // three pushes while enabled; second push coincides with the first pop
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h3C;
    @(negedge clk);
    wr_if.wr_data = 8'hC3;
    chk("pp_count0", {29'd0, fifo_count}, 32'd1);
    @(negedge clk);
    wr_if.wr_data = 8'h81;
    chk("pp_count1", {29'd0, fifo_count}, 32'd1);
    chk("pp_txd0",   {31'd0, txd},        32'd0);
    chk("pp_busy0",  {31'd0, tx_busy},    32'd1);
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    chk("pp_count2", {29'd0, fifo_count}, 32'd2);
    chk("pp_txd1",   {31'd0, txd},        32'd0);
    frame_check("dis", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 1, 2, 4);
    // disable and change parity during DATA: frame finishes unchanged
    tx_en       = 1'b0;
    parity_mode = PAR_EVEN;
    frame_check("dis", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 1, 4, 20);
    repeat (6) begin
      @(negedge clk);
      idle_check("dis_post", 2);
    end

    // reset in the middle of a data bit
    tx_en       = 1'b1;
    parity_mode = PAR_NONE;
    @(negedge clk);
    chk("rmf_pre_txd", {31'd0, txd}, 32'd1);
    frame_check("rmf", {6'd0, 1'b1, 8'hC3, 1'b0}, 10, 1, 0, 6);
    @(negedge clk);
    chk("rmf_bit2", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    idle_check("rmf_rst", 0);
    chk("rmf_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h0F;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    chk("rmf_new_txd",   {31'd0, txd},        32'd1);
    chk("rmf_new_count", {29'd0, fifo_count}, 32'd1);
    frame_check("rmf_new", {6'd0, 1'b1, 8'h0F, 1'b0}, 10, 1, 0, 20);
    @(negedge clk);
    idle_check("rmf_new_post", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
